// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: parallel-in, serial-out asynchronous transmitter.
// Frame = start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Every bit is held for CLKS_PER_BIT clocks; txd comes straight from a flop.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, tx_ready=1, waiting for tx_valid
// S_START  | start bit (txd=0)
// S_DATA   | data bits, shift_q[0] on the line, idx_q = bit number
// S_PARITY | parity of the latched word (even/odd)
// S_STOP   | stop bit(s), idx_q = stop bit number
module uart_tx_serializer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic             PAR_ODD   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic               par_q, par_d;
   logic               txd_q, txd_d;
   logic               done_q, done_d;
   logic               bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // Next-state logic; txd_d is the line level for the state being entered,
   // so the line changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd_q;
      done_d  = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (tx_valid) begin
               state_d = S_START;
               shift_d = tx_data;
               par_d   = (^tx_data) ^ PAR_ODD;
               cnt_d   = '0;
               idx_d   = '0;
               txd_d   = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
               txd_d   = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == DATA_LAST) begin
                  idx_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = S_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
                  txd_d = shift_d[0];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
               txd_d   = 1'b1;
            end
         end
         S_STOP: begin
            txd_d = 1'b1;
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // State and datapath registers, async active-low reset to idle line.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   assign tx_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign txd      = txd_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (plain, even parity + 2 stop,
// odd parity) share stimulus; a frame-playback model predicts every output.
module tb_uart_tx_serializer;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       ready[3];
   logic       txd[3];
   logic       busy[3];
   logic       done[3];

   int errors = 0;
   int checks = 0;

   int pe_c[3] = '{0, 1, 1};
   int po_c[3] = '{0, 0, 1};
   int sb_c[3] = '{1, 2, 1};

   // model: pos = -1 idle, else index into the expanded frame waveform
   int   pos[3]    = '{-1, -1, -1};
   int   flen[3]   = '{0, 0, 0};
   logic done_m[3] = '{1'b0, 1'b0, 1'b0};
   logic wv[3][0:127];

   typedef struct {
      logic [7:0] data;
      logic       par_even;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
      .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_even (
      .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));

   task automatic chk(input string name, input int k, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %b expected %b at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, k, act, exp, $time);
      end
   endtask

   function automatic void load_frame(input int k, input logic [7:0] d);
      int bits[$];
      bits.push_back(0);
      for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
      if (pe_c[k] != 0) bits.push_back(($countones(d) + po_c[k]) % 2);
      for (int s = 0; s < sb_c[k]; s++) bits.push_back(1);
      flen[k] = bits.size() * C;
      for (int i = 0; i < flen[k]; i++) wv[k][i] = (bits[i / C] != 0);
   endfunction

   // reference model: a handshake loads a whole frame waveform, which then plays out
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 3; k++) begin
            pos[k]    = -1;
            done_m[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            done_m[k] = 1'b0;
            if (pos[k] >= 0) begin
               pos[k]++;
               if (pos[k] == flen[k]) begin
                  pos[k]    = -1;
                  done_m[k] = 1'b1;
               end
            end else if (tx_valid) begin
               load_frame(k, tx_data);
               pos[k] = 0;
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("txd", k, txd[k], (pos[k] < 0) ? 1'b1 : wv[k][pos[k]]);
         chk("tx_ready", k, ready[k], pos[k] < 0);
         chk("busy", k, busy[k], pos[k] >= 0);
         chk("done", k, done[k], done_m[k]);
      end
   end

   task automatic wait_all_idle();
      int n = 0;
      while (!(ready[0] && ready[1] && ready[2]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 0, ready[0] && ready[1] && ready[2], 1'b1);
   endtask

   task automatic do_frame(input logic [7:0] d, input bit chk_par, input logic par_even);
      int rl = 0;
      int dn = 0;
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int o = 0; o < 60; o++) begin
         if (o > 0) @(negedge clk);
         if (!ready[0]) rl++;
         if (done[0]) dn++;
         if (chk_par && o == 37) begin
            chk("parity_even_bit", 1, txd[1], par_even);
            chk("parity_odd_bit", 2, txd[2], ~par_even);
         end
         if (o == 47) begin
            chk("second_stop_txd", 1, txd[1], 1'b1);
            chk("second_stop_busy", 1, busy[1], 1'b1);
         end
         if (o == 48) chk("stop2_done", 1, done[1], 1'b1);
      end
      chk_int("ready_low_cycles", 0, rl, 10 * C);
      chk_int("done_pulses", 0, dn, 1);
      wait_all_idle();
   endtask

   initial begin
      int ones;
      int rises;
      logic prev;

      tbl[0] = '{8'hA5, 1'b0};
      tbl[1] = '{8'h07, 1'b1};
      tbl[2] = '{8'h00, 1'b0};
      tbl[3] = '{8'hFF, 1'b0};
      tbl[4] = '{8'h01, 1'b1};
      tbl[5] = '{8'h5A, 1'b0};

      // reset held with tx_valid high: nothing starts
      rstn     = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk("rst_txd", k, txd[k], 1'b1);
            chk("rst_ready", k, ready[k], 1'b1);
            chk("rst_busy", k, busy[k], 1'b0);
            chk("rst_done", k, done[k], 1'b0);
         end
      end
      tx_valid = 1'b0;
      rstn     = 1'b1;
      @(negedge clk);
      chk("no_frame_after_rst", 0, busy[0], 1'b0);

      // table-driven frames
      for (int i = 0; i < 6; i++) do_frame(tbl[i].data, 1'b1, tbl[i].par_even);

      // back-to-back with tx_valid held high: 0x00 then 0xFF
      @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hFF;
      ones = 0;
      for (int o = 1; o < 100; o++) begin
         @(negedge clk);
         if (o == 39) chk("b2b_last_stop", 0, txd[0], 1'b1);
         if (o == 40) begin
            chk("b2b_idle_txd", 0, txd[0], 1'b1);
            chk("b2b_idle_done", 0, done[0], 1'b1);
            chk("b2b_idle_ready", 0, ready[0], 1'b1);
         end
         if (o == 41) begin
            chk("b2b_start_txd", 0, txd[0], 1'b0);
            chk("b2b_start_busy", 0, busy[0], 1'b1);
            tx_valid = 1'b0;
         end
         if (o >= 45 && o <= 76 && txd[0]) ones++;
      end
      chk_int("b2b_second_data_ones", 0, ones, 8 * C);
      wait_all_idle();

      // reset during data bit 3, then a clean frame
      @(negedge clk);
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("midrst_txd", k, txd[k], 1'b1);
         chk("midrst_busy", k, busy[k], 1'b0);
         chk("midrst_ready", k, ready[k], 1'b1);
      end
      @(negedge clk);
      rstn = 1'b1;
      do_frame(8'h3C, 1'b1, 1'b0);

      // interference while busy: random tx_data and tx_valid pulses
      for (int it = 0; it < 3; it++) begin
         @(negedge clk);
         tx_data  = 8'($urandom);
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         rises = 0;
         prev  = busy[0];
         for (int o = 1; o < 60; o++) begin
            @(negedge clk);
            if (busy[0] && !prev) rises++;
            prev = busy[0];
            if (o <= 35) begin
               tx_data  = 8'($urandom);
               tx_valid = 1'($urandom_range(0, 1));
            end else begin
               tx_valid = 1'b0;
            end
         end
         chk_int("extra_frames", 0, rises, 0);
         wait_all_idle();
      end

      // random words
      for (int i = 0; i < 4; i++) do_frame(8'($urandom), 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
